// File: rtl/pfc_pkg.sv
// Shared types and default sizes for the parity frame controller.
package pfc_pkg;

    // Frame receive states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        REPORT = 2'd3
    } pfc_state_e;

    localparam int PFC_DATA_W = 4;
    localparam int PFC_CNT_W  = 8;

endpackage

// File: rtl/par_xor_reduce.sv
// Combinational even-parity checker: XOR of a data bus and its parity bit.
module par_xor_reduce #(
    parameter int W = 4
) (
    input  logic [W-1:0] data_i,
    input  logic         par_i,
    output logic         err_o
);

    // An odd count of ones across data and parity means a parity error.
    assign err_o = (^data_i) ^ par_i;

endmodule

// File: rtl/parity_frame_controller.sv
// Serial frame receiver: DATA_W data bits LSB first, then one even-parity bit.
// The saturating parity-error counter is built only when PFC_ERR_CNT_EN is defined;
// otherwise err_count is tied to 0 and cnt_clr is ignored.
module parity_frame_controller
    import pfc_pkg::*;
#(
    parameter int DATA_W = PFC_DATA_W,
    parameter int CNT_W  = PFC_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              cnt_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_done,
    output logic              parity_err,
    output logic [CNT_W-1:0]  err_count,
    output logic              busy
);

    // Wide enough to hold 0..DATA_W.
    localparam int BitW = $clog2(DATA_W + 1);

    pfc_state_e        state_q, state_d;
    logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_done_q, frame_done_d;
    logic              accept;
    logic              par_err;

    assign din_ready  = (state_q != REPORT);
    assign busy       = (state_q != IDLE);
    assign accept     = din_valid && din_ready;
    assign data_out   = data_out_q;
    assign parity_err = parity_err_q;
    assign frame_done = frame_done_q;

    par_xor_reduce #(
        .W (DATA_W)
    ) u_par_xor_reduce (
        .data_i (cap_q),
        .par_i  (din),
        .err_o  (par_err)
    );

    // Next-state logic: capture data bits, then latch the frame result on the parity bit.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        cap_d        = cap_q;
        data_out_d   = data_out_q;
        parity_err_d = parity_err_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cap_d     = '0;
                    cap_d[0]  = din;
                    bit_cnt_d = BitW'(1);
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    for (int i = 1; i < DATA_W; i++) begin
                        if (bit_cnt_q == BitW'(i)) begin
                            cap_d[i] = din;
                        end
                    end
                    bit_cnt_d = bit_cnt_q + BitW'(1);
                    if (bit_cnt_q == BitW'(DATA_W - 1)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (accept) begin
                    data_out_d   = cap_q;
                    parity_err_d = par_err;
                    frame_done_d = 1'b1;
                    bit_cnt_d    = '0;
                    state_d      = REPORT;
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            cap_q        <= '0;
            data_out_q   <= '0;
            parity_err_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            cap_q        <= cap_d;
            data_out_q   <= data_out_d;
            parity_err_q <= parity_err_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef PFC_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Saturating error count; clear wins over a same-cycle increment.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (cnt_clr) begin
            err_cnt_d = '0;
        end else if ((state_q == REPORT) && parity_err_q && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign err_count      = '0;
`endif

endmodule

// File: tb/tb_parity_frame_controller.sv
// Directed self-checking bench for parity_frame_controller (DATA_W = 4, CNT_W = 2).
module tb_parity_frame_controller;

    logic       clk;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       din_ready;
    logic       cnt_clr;
    logic [3:0] data_out;
    logic       frame_done;
    logic       parity_err;
    logic [1:0] err_count;
    logic       busy;

    int         errors;
    int         checks;
    logic [1:0] exp_cnt;

    parity_frame_controller #(
        .DATA_W (4),
        .CNT_W  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .cnt_clr    (cnt_clr),
        .data_out   (data_out),
        .frame_done (frame_done),
        .parity_err (parity_err),
        .err_count  (err_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] cnt_expect(input logic [1:0] c);
`ifdef PFC_ERR_CNT_EN
        return c;
`else
        return 2'd0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send one frame with gap idle cycles after each data bit; check the REPORT cycle
    // and the IDLE cycle after it. hold keeps din_valid=1 (din=1) through REPORT.
    task automatic run_frame(input string name, input logic [3:0] d, input logic p,
                             input int gap, input logic exp_err, input logic clr,
                             input logic hold);
        for (int i = 0; i < 5; i++) begin
            din       = (i < 4) ? d[i] : p;
            din_valid = 1'b1;
            step();
            if (i < 4 && gap > 0) begin
                din_valid = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    checks++;
                    if (busy !== 1'b1 || din_ready !== 1'b1 || frame_done !== 1'b0) begin
                        errors++;
                        $display("FAIL %s stall: busy=%b ready=%b done=%b, need 1 1 0",
                                 name, busy, din_ready, frame_done);
                    end
                    step();
                end
            end
        end
        checks++;
        if (frame_done !== 1'b1 || din_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s report: done=%b ready=%b busy=%b, need 1 0 1",
                     name, frame_done, din_ready, busy);
        end
        checks++;
        if (data_out !== d || parity_err !== exp_err) begin
            errors++;
            $display("FAIL %s result: data_out=%b parity_err=%b, need %b %b",
                     name, data_out, parity_err, d, exp_err);
        end
        if (clr) cnt_clr = 1'b1;
        if (hold) begin
            din       = 1'b1;
            din_valid = 1'b1;
        end else begin
            din_valid = 1'b0;
        end
        step();
        cnt_clr = 1'b0;
        if (clr) exp_cnt = 2'd0;
        else if (exp_err && exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s post-report: done=%b busy=%b ready=%b, need 0 0 1",
                     name, frame_done, busy, din_ready);
        end
        checks++;
        if (err_count !== cnt_expect(exp_cnt)) begin
            errors++;
            $display("FAIL %s err_count: got %0d, need %0d", name, err_count,
                     cnt_expect(exp_cnt));
        end
        checks++;
        if (data_out !== d || parity_err !== exp_err) begin
            errors++;
            $display("FAIL %s hold: data_out=%b parity_err=%b, need %b %b",
                     name, data_out, parity_err, d, exp_err);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        din       = 1'b1;
        din_valid = 1'b1;
        cnt_clr   = 1'b1;
        step();
        step();
        checks++;
        if (frame_done !== 1'b0 || parity_err !== 1'b0 || data_out !== 4'b0000 ||
            err_count !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: done=%b perr=%b data=%b cnt=%0d busy=%b, need 0 0 0000 0 0",
                     frame_done, parity_err, data_out, err_count, busy);
        end
        din_valid = 1'b0;
        cnt_clr   = 1'b0;
        rst       = 1'b0;
        exp_cnt   = 2'd0;
        step();
        checks++;
        if (busy !== 1'b0 || din_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: busy=%b ready=%b, need 0 1", busy, din_ready);
        end
    endtask

    task automatic test_good_frame();
        run_frame("good", 4'b1011, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_bad_frame();
        run_frame("bad", 4'b1011, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        run_frame("stall", 4'b0100, 1'b1, 3, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        din       = 1'b1;
        din_valid = 1'b1;
        step();
        din = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst       = 1'b0;
        din_valid = 1'b0;
        exp_cnt   = 2'd0;
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0 || data_out !== 4'b0000 ||
            err_count !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b done=%b data=%b cnt=%0d, need 0 0 0000 0",
                     busy, frame_done, data_out, err_count);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (frame_done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_quiet: done=%b busy=%b, need 0 0", frame_done, busy);
            end
        end
        run_frame("after_reset", 4'b1011, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            run_frame("sat", 4'b0111, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        end
        run_frame("clr", 4'b0001, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_first", 4'b0110, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        run_frame("b2b_second", 4'b1011, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        exp_cnt   = 2'd0;
        rst       = 1'b1;
        din       = 1'b0;
        din_valid = 1'b0;
        cnt_clr   = 1'b0;
        test_reset();
        test_good_frame();
        test_bad_frame();
        test_stall();
        test_reset_mid_frame();
        test_saturation();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
